// File: rtl/vending_controller.sv
// Micro-vending transaction controller: item selection, coin accumulation with a
// 99-unit ceiling, cancel/refund, one-cycle dispense and a timed change display.
module vending_controller #(
    parameter logic [7:0]  PRICE_0     = 8'd15,
    parameter logic [7:0]  PRICE_1     = 8'd25,
    parameter logic [7:0]  PRICE_2     = 8'd40,
    parameter logic [7:0]  PRICE_3     = 8'd60,
    parameter logic [7:0]  MAX_MONEY   = 8'd99,
    parameter logic [31:0] HOLD_CYCLES = 32'd300_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sel_valid,
    input  logic [1:0] item_sel,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       cancel,
    output logic [7:0] need_money,
    output logic [7:0] input_money,
    output logic [7:0] change_money,
    output logic       dispense_valid,
    output logic [1:0] dispense_item,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned MW = 8;
    localparam int unsigned SW = 9;
    localparam int unsigned CW = 32;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PAY      = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]    state, state_n;
    logic [1:0]    item, item_n;
    logic [MW-1:0] need_n, input_n, change_n;
    logic [CW-1:0] hold_cnt, hold_n;
    logic          dispense_valid_n, coin_reject_n, busy_n;
    logic [1:0]    dispense_item_n;
    logic [SW-1:0] coin_sum, total;
    logic [MW-1:0] sel_price;
    logic          coin_any, start;

    // State and all outputs are registered together
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            item           <= 2'd0;
            need_money     <= '0;
            input_money    <= '0;
            change_money   <= '0;
            hold_cnt       <= '0;
            dispense_valid <= 1'b0;
            dispense_item  <= 2'd0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            item           <= item_n;
            need_money     <= need_n;
            input_money    <= input_n;
            change_money   <= change_n;
            hold_cnt       <= hold_n;
            dispense_valid <= dispense_valid_n;
            dispense_item  <= dispense_item_n;
            coin_reject    <= coin_reject_n;
            busy           <= busy_n;
        end
    end

    always_comb begin
        state_n       = state;
        item_n        = item;
        need_n        = need_money;
        input_n       = input_money;
        change_n      = change_money;
        hold_n        = hold_cnt;
        coin_reject_n = 1'b0;
        start         = 1'b0;

        coin_any = coin_1 | coin_5 | coin_10;
        coin_sum = SW'(coin_1) + (coin_5 ? SW'(5) : SW'(0)) + (coin_10 ? SW'(10) : SW'(0));
        total    = SW'(input_money) + coin_sum;

        case (item_sel)
            2'd0:    sel_price = PRICE_0;
            2'd1:    sel_price = PRICE_1;
            2'd2:    sel_price = PRICE_2;
            default: sel_price = PRICE_3;
        endcase

        case (state)
            IDLE: begin
                coin_reject_n = coin_any;
                start         = sel_valid;
            end
            PAY: begin
                if (cancel) begin
                    // Cancel wins over same-cycle coins, which are refused
                    coin_reject_n = coin_any;
                    change_n      = input_money;
                    input_n       = '0;
                    need_n        = '0;
                    hold_n        = '0;
                    state_n       = DONE;
                end else begin
                    if (total <= SW'(MAX_MONEY)) input_n = MW'(total);
                    else                         coin_reject_n = coin_any;
                    if (input_money >= need_money) state_n = DISPENSE;
                end
            end
            DISPENSE: begin
                coin_reject_n = coin_any;
                change_n      = input_money - need_money;
                need_n        = '0;
                input_n       = '0;
                hold_n        = '0;
                state_n       = DONE;
            end
            DONE: begin
                coin_reject_n = coin_any;
                start         = sel_valid;
                if (hold_cnt == HOLD_CYCLES - 32'd1) begin
                    change_n = '0;
                    hold_n   = '0;
                    state_n  = IDLE;
                end else begin
                    hold_n = hold_cnt + 32'd1;
                end
            end
        endcase

        // A new selection from IDLE or DONE overrides the hold timeout
        if (start) begin
            need_n   = sel_price;
            item_n   = item_sel;
            input_n  = '0;
            change_n = '0;
            hold_n   = '0;
            state_n  = PAY;
        end

        dispense_valid_n = (state_n == DISPENSE);
        dispense_item_n  = (state_n == DISPENSE) ? item_n : 2'd0;
        busy_n           = (state_n != IDLE);
    end

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: two instances (default prices and PRICE_3=99),
// directed stimulus with hand-computed expectations and an event monitor.
module tb_vending_controller;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst_n;
    logic       tgt;
    logic       d_sel, d_c1, d_c5, d_c10, d_cancel;
    logic [1:0] d_item;

    logic [7:0] a_need, a_input, a_change, b_need, b_input, b_change;
    logic       a_dv, a_rej, a_busy, b_dv, b_rej, b_busy;
    logic [1:0] a_item, b_item;

    logic [7:0] o_need, o_input, o_change;
    logic       o_dv, o_rej, o_busy;
    logic [1:0] o_item;

    vending_controller #(.HOLD_CYCLES(32'd8)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .sel_valid(d_sel & ~tgt), .item_sel(d_item),
        .coin_1(d_c1 & ~tgt), .coin_5(d_c5 & ~tgt), .coin_10(d_c10 & ~tgt),
        .cancel(d_cancel & ~tgt),
        .need_money(a_need), .input_money(a_input), .change_money(a_change),
        .dispense_valid(a_dv), .dispense_item(a_item), .coin_reject(a_rej), .busy(a_busy)
    );

    vending_controller #(.PRICE_3(8'd99), .HOLD_CYCLES(32'd8)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .sel_valid(d_sel & tgt), .item_sel(d_item),
        .coin_1(d_c1 & tgt), .coin_5(d_c5 & tgt), .coin_10(d_c10 & tgt),
        .cancel(d_cancel & tgt),
        .need_money(b_need), .input_money(b_input), .change_money(b_change),
        .dispense_valid(b_dv), .dispense_item(b_item), .coin_reject(b_rej), .busy(b_busy)
    );

    assign o_need   = tgt ? b_need   : a_need;
    assign o_input  = tgt ? b_input  : a_input;
    assign o_change = tgt ? b_change : a_change;
    assign o_dv     = tgt ? b_dv     : a_dv;
    assign o_item   = tgt ? b_item   : a_item;
    assign o_rej    = tgt ? b_rej    : a_rej;
    assign o_busy   = tgt ? b_busy   : a_busy;

    // kind 1 = dispense, 0 = coin refusal
    typedef struct packed {
        logic       kind;
        logic [1:0] item;
        logic [7:0] need;
        logic [7:0] inp;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_event(input ev_t got);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: kind=%0d item=%0d need=%0d input=%0d at %0t",
                     got.kind, got.item, got.need, got.inp, $time);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL event: got kind=%0d item=%0d need=%0d input=%0d expected kind=%0d item=%0d need=%0d input=%0d at %0t",
                         got.kind, got.item, got.need, got.inp, e.kind, e.item, e.need, e.inp, $time);
            end
        end
    endtask

    // Monitor: any dispense or refusal pulse must match the next queued expectation
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (o_dv)  check_event(ev_t'{1'b1, o_item, o_need, o_input});
            if (o_rej) check_event(ev_t'{1'b0, 2'd0, o_need, o_input});
        end
    end

    task automatic pulse(input logic c1, input logic c5, input logic c10,
                         input logic cn, input logic sv, input logic [1:0] it);
        d_c1 = c1; d_c5 = c5; d_c10 = c10; d_cancel = cn; d_sel = sv; d_item = it;
        @(posedge sys_clk);
        #1;
        d_c1 = 1'b0; d_c5 = 1'b0; d_c10 = 1'b0; d_cancel = 1'b0; d_sel = 1'b0; d_item = 2'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic sel(input logic [1:0] it); pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, it); endtask
    task automatic c1();  pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); endtask
    task automatic c5();  pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0); endtask
    task automatic c10(); pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tgt = 1'b0; sys_rst_n = 1'b0;
        d_sel = 1'b0; d_c1 = 1'b0; d_c5 = 1'b0; d_c10 = 1'b0; d_cancel = 1'b0; d_item = 2'd0;
        #12;
        chk("rst_need", int'(o_need), 0);
        chk("rst_input", int'(o_input), 0);
        chk("rst_change", int'(o_change), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_dv", int'(o_dv), 0);
        sys_rst_n = 1'b1;
        tick(1);

        // Item 1 (25): 10, 10, 5
        sel(2'd1);
        chk("t1_need", int'(o_need), 25);
        chk("t1_busy", int'(o_busy), 1);
        c10(); chk("t1_in10", int'(o_input), 10);
        c10(); chk("t1_in20", int'(o_input), 20);
        exp_q.push_back(ev_t'{1'b1, 2'd1, 8'd25, 8'd25});
        c5();  chk("t1_in25", int'(o_input), 25);
        chk("t1_dv_early", int'(o_dv), 0);
        tick(1);
        chk("t1_dv", int'(o_dv), 1);
        chk("t1_item", int'(o_item), 1);
        tick(1);
        chk("t1_dv_off", int'(o_dv), 0);
        chk("t1_change", int'(o_change), 0);
        chk("t1_need0", int'(o_need), 0);
        chk("t1_in0", int'(o_input), 0);
        tick(7); chk("t1_hold_busy", int'(o_busy), 1);
        tick(1); chk("t1_idle", int'(o_busy), 0);

        // Item 0 (15): 10 then 10+5 together
        sel(2'd0);
        chk("t2_need", int'(o_need), 15);
        c10(); chk("t2_in10", int'(o_input), 10);
        exp_q.push_back(ev_t'{1'b1, 2'd0, 8'd15, 8'd25});
        pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("t2_in25", int'(o_input), 25);
        tick(1); chk("t2_dv", int'(o_dv), 1); chk("t2_item", int'(o_item), 0);
        tick(1); chk("t2_change", int'(o_change), 10); chk("t2_need0", int'(o_need), 0);
        tick(7); chk("t2_change_held", int'(o_change), 10);
        tick(1); chk("t2_change_clr", int'(o_change), 0); chk("t2_idle", int'(o_busy), 0);

        // Item 3 (60) price check, plain cancel with no coins
        sel(2'd3);
        chk("t3_need", int'(o_need), 60);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        chk("t3_cancel_change", int'(o_change), 0);
        chk("t3_cancel_need", int'(o_need), 0);
        tick(8); chk("t3_idle", int'(o_busy), 0);

        // Saturation and exact-99 boundary on the PRICE_3=99 instance
        tgt = 1'b1;
        sel(2'd3);
        chk("t3b_need", int'(o_need), 99);
        for (int i = 0; i < 9; i++) c10();
        chk("t3b_in90", int'(o_input), 90);
        c5(); chk("t3b_in95", int'(o_input), 95);
        exp_q.push_back(ev_t'{1'b0, 2'd0, 8'd99, 8'd95});
        c10();
        chk("t3b_rej", int'(o_rej), 1);
        chk("t3b_in_hold", int'(o_input), 95);
        tick(1); chk("t3b_rej_off", int'(o_rej), 0);
        for (int i = 0; i < 3; i++) c1();
        chk("t3b_in98", int'(o_input), 98);
        exp_q.push_back(ev_t'{1'b1, 2'd3, 8'd99, 8'd99});
        c1();
        chk("t3b_in99", int'(o_input), 99);
        chk("t3b_no_rej", int'(o_rej), 0);
        tick(1); chk("t3b_dv", int'(o_dv), 1); chk("t3b_item", int'(o_item), 3);
        tick(1); chk("t3b_change", int'(o_change), 0);
        tick(8); chk("t3b_idle", int'(o_busy), 0);
        tgt = 1'b0;

        // Item 2 (40): 30 paid, then cancel with a same-cycle 5 coin
        sel(2'd2);
        chk("t4_need", int'(o_need), 40);
        for (int i = 0; i < 3; i++) c10();
        chk("t4_in30", int'(o_input), 30);
        exp_q.push_back(ev_t'{1'b0, 2'd0, 8'd0, 8'd0});
        pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        chk("t4_change", int'(o_change), 30);
        chk("t4_rej", int'(o_rej), 1);
        chk("t4_need0", int'(o_need), 0);
        chk("t4_in0", int'(o_input), 0);
        chk("t4_no_dv", int'(o_dv), 0);
        tick(8); chk("t4_idle", int'(o_busy), 0); chk("t4_change_clr", int'(o_change), 0);

        // Coin while idle is refused
        exp_q.push_back(ev_t'{1'b0, 2'd0, 8'd0, 8'd0});
        c1();
        chk("t5_rej", int'(o_rej), 1);
        chk("t5_in0", int'(o_input), 0);
        chk("t5_busy", int'(o_busy), 0);
        tick(1);

        // New selection while change is still displayed
        sel(2'd0);
        c10();
        exp_q.push_back(ev_t'{1'b1, 2'd0, 8'd15, 8'd20});
        c10(); chk("t5_in20", int'(o_input), 20);
        tick(1); chk("t5_dv", int'(o_dv), 1);
        tick(1); chk("t5_change5", int'(o_change), 5);
        tick(2);
        sel(2'd1);
        chk("t5_resel_change", int'(o_change), 0);
        chk("t5_resel_need", int'(o_need), 25);
        chk("t5_resel_in", int'(o_input), 0);
        chk("t5_resel_busy", int'(o_busy), 1);

        // Asynchronous reset mid-PAY with 20 paid
        c10(); c10();
        chk("t6_in20", int'(o_input), 20);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_need", int'(o_need), 0);
        chk("t6_rst_input", int'(o_input), 0);
        chk("t6_rst_change", int'(o_change), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        #2 sys_rst_n = 1'b1;
        tick(1);
        chk("t6_post_busy", int'(o_busy), 0);
        chk("t6_post_input", int'(o_input), 0);

        tick(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
